// File: rtl/gate_sweep_tester_pkg.sv
// Shared definitions for the gate sweep tester: gate function codes and FSM state encoding.
package gate_sweep_tester_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_XNOR = 4;
    localparam int OP_NOT  = 5;
    localparam int OP_NOR  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gate_sweep_tester_golden.sv
// Combinational reference model of the two-input bitwise gate selected by OP.
module gate_sweep_tester_golden
    import gate_sweep_tester_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int OP    = OP_NOR
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    always_comb begin
        c = '0;
        case (OP)
            OP_AND:  c = a & b;
            OP_OR:   c = a | b;
            OP_XOR:  c = a ^ b;
            OP_NAND: c = ~(a & b);
            OP_XNOR: c = ~(a ^ b);
            OP_NOT:  c = ~a;
            OP_NOR:  c = ~(a | b);
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_tester.sv
// Sweeps every (a,b) pair onto a gate under test and checks its c output against a golden model.
//  state  | meaning
//  IDLE   | after reset, waiting for start
//  DRIVE  | present vec on a_out/b_out
//  SETTLE | count down settle time before sampling c_in
//  CHECK  | compare c_in with golden result, advance vec
//  DONE   | results held until next start
module gate_sweep_tester
    import gate_sweep_tester_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int OP     = OP_NOR,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH-1:0]     c_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int VW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [VW-1:0] VEC_MAX     = {VW{1'b1}};
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE > 0) ? (SETTLE - 1) : 0);

    state_t          state;
    state_t          state_next;
    logic [VW-1:0]   vec;
    logic [SW-1:0]   settle_cnt;
    logic [WIDTH-1:0] expected;
    logic            mismatch;
    logic [EW-1:0]   err_next;

    gate_sweep_tester_golden #(
        .WIDTH (WIDTH),
        .OP    (OP)
    ) u_golden (
        .a (a_out),
        .b (b_out),
        .c (expected)
    );

    assign mismatch = (c_in != expected);
    assign err_next = err_count + EW'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_DRIVE;
            ST_DRIVE:         state_next = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
            ST_SETTLE:        if (settle_cnt == '0) state_next = ST_CHECK;
            ST_CHECK:         state_next = (vec == VEC_MAX) ? ST_DONE : ST_DRIVE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec       <= '0;
                        err_count <= '0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    a_out      <= vec[WIDTH-1:0];
                    b_out      <= vec[VW-1:WIDTH];
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        // only the first failing vector is kept
                        if (err_count == '0) begin
                            fail_a <= a_out;
                            fail_b <= b_out;
                        end
                    end
                    if (vec == VEC_MAX) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= (err_next == '0);
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Directed bench for gate_sweep_tester: three tester instances against a modelled NOR gate.
module tb_gate_sweep_tester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [3];
    logic [2:0] a_v [3];
    logic [2:0] b_v [3];
    logic [2:0] c_v [3];
    logic       busy_v [3];
    logic       done_v [3];
    logic       pass_v [3];
    logic [6:0] err_v [3];
    logic [2:0] fa_v [3];
    logic [2:0] fb_v [3];
    logic       fault_nor = 1'b0;
    logic       fault_s0 = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // gate under test is a NOR core for all three testers; faults force a stuck bit 0
    assign c_v[0] = fault_nor ? (~(a_v[0] | b_v[0]) & 3'b110) : ~(a_v[0] | b_v[0]);
    assign c_v[1] = ~(a_v[1] | b_v[1]);
    assign c_v[2] = fault_s0 ? (~(a_v[2] | b_v[2]) | 3'b001) : ~(a_v[2] | b_v[2]);

    gate_sweep_tester #(.WIDTH(3), .OP(6), .SETTLE(1)) dut_nor (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
        .c_in(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .fail_a(fa_v[0]), .fail_b(fb_v[0]));

    gate_sweep_tester #(.WIDTH(3), .OP(1), .SETTLE(1)) dut_or (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
        .c_in(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .fail_a(fa_v[1]), .fail_b(fb_v[1]));

    gate_sweep_tester #(.WIDTH(3), .OP(6), .SETTLE(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
        .c_in(c_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .fail_a(fa_v[2]), .fail_b(fb_v[2]));

    // start is high across exactly one rising edge; returns #1 after that edge
    task automatic start_pulse(input int sel);
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
    endtask

    // counts edges until done; optionally re-pulses start at cycles 10 and 100
    task automatic wait_done(input int sel, input bit repulse, output int cycles);
        cycles = 0;
        while (cycles < 1000) begin
            @(posedge clk);
            cycles++;
            #1;
            start_v[sel] = repulse && (cycles == 10 || cycles == 100);
            if (done_v[sel]) break;
        end
        start_v[sel] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if ({a_v[s], b_v[s], busy_v[s], done_v[s], pass_v[s], err_v[s], fa_v[s], fb_v[s]} !== 22'd0)
                $display("FAIL reset_outputs dut%0d: got a=%0d b=%0d busy=%0b done=%0b pass=%0b err=%0d fa=%0d fb=%0d, expected all 0",
                         s, a_v[s], b_v[s], busy_v[s], done_v[s], pass_v[s], err_v[s], fa_v[s], fb_v[s]);
            else n_pass++;
        end
    endtask

    task automatic test_nor_pass();
        int cyc;
        start_pulse(0);
        n_checks++;
        if (busy_v[0] !== 1'b1) $display("FAIL busy_after_start: got %0b expected 1", busy_v[0]);
        else n_pass++;
        wait_done(0, 1'b0, cyc);
        n_checks++;
        if (cyc != 192) $display("FAIL nor_latency: got %0d expected 192", cyc);
        else n_pass++;
        n_checks++;
        if ({pass_v[0], err_v[0]} !== {1'b1, 7'd0})
            $display("FAIL nor_pass: got pass=%0b err=%0d expected pass=1 err=0", pass_v[0], err_v[0]);
        else n_pass++;
        n_checks++;
        if ({a_v[0], b_v[0], busy_v[0]} !== {3'd7, 3'd7, 1'b0})
            $display("FAIL nor_final_vec: got a=%0d b=%0d busy=%0b expected a=7 b=7 busy=0", a_v[0], b_v[0], busy_v[0]);
        else n_pass++;
    endtask

    task automatic test_stuck_bit();
        int cyc;
        fault_nor = 1'b1;
        start_pulse(0);
        wait_done(0, 1'b0, cyc);
        fault_nor = 1'b0;
        n_checks++;
        if (cyc != 192) $display("FAIL stuck_latency: got %0d expected 192", cyc);
        else n_pass++;
        n_checks++;
        if (err_v[0] !== 7'd16) $display("FAIL stuck_err_count: got %0d expected 16", err_v[0]);
        else n_pass++;
        n_checks++;
        if ({pass_v[0], fa_v[0], fb_v[0]} !== 7'd0)
            $display("FAIL stuck_fail_vec: got pass=%0b fa=%0d fb=%0d expected 0 0 0", pass_v[0], fa_v[0], fb_v[0]);
        else n_pass++;
    endtask

    task automatic test_wrong_op();
        int cyc;
        start_pulse(1);
        wait_done(1, 1'b0, cyc);
        n_checks++;
        if (err_v[1] !== 7'd64) $display("FAIL wrong_op_err_count: got %0d expected 64", err_v[1]);
        else n_pass++;
        n_checks++;
        if ({pass_v[1], fa_v[1], fb_v[1]} !== 7'd0)
            $display("FAIL wrong_op_fail_vec: got pass=%0b fa=%0d fb=%0d expected 0 0 0", pass_v[1], fa_v[1], fb_v[1]);
        else n_pass++;
    endtask

    task automatic test_busy_restart();
        int cyc;
        start_pulse(0);
        wait_done(0, 1'b1, cyc);
        n_checks++;
        if (cyc != 192) $display("FAIL busy_restart_latency: got %0d expected 192", cyc);
        else n_pass++;
        n_checks++;
        if (pass_v[0] !== 1'b1) $display("FAIL busy_restart_pass: got %0b expected 1", pass_v[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_pulse(0);
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fa_v[0], fb_v[0]} !== 22'd0)
            $display("FAIL mid_reset_outputs: got a=%0d b=%0d busy=%0b done=%0b err=%0d expected all 0",
                     a_v[0], b_v[0], busy_v[0], done_v[0], err_v[0]);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_pulse(0);
        wait_done(0, 1'b0, cyc);
        n_checks++;
        if (cyc != 192) $display("FAIL post_reset_latency: got %0d expected 192", cyc);
        else n_pass++;
        n_checks++;
        if ({pass_v[0], err_v[0]} !== {1'b1, 7'd0})
            $display("FAIL post_reset_pass: got pass=%0b err=%0d expected 1 0", pass_v[0], err_v[0]);
        else n_pass++;
    endtask

    task automatic test_restart_in_done();
        int cyc;
        fault_s0 = 1'b1;
        start_pulse(2);
        wait_done(2, 1'b0, cyc);
        fault_s0 = 1'b0;
        n_checks++;
        if (cyc != 128) $display("FAIL s0_latency: got %0d expected 128", cyc);
        else n_pass++;
        n_checks++;
        if ({err_v[2], fa_v[2], fb_v[2]} !== {7'd48, 3'd1, 3'd0})
            $display("FAIL s0_fault_capture: got err=%0d fa=%0d fb=%0d expected 48 1 0", err_v[2], fa_v[2], fb_v[2]);
        else n_pass++;
        start_pulse(2);
        n_checks++;
        if ({done_v[2], busy_v[2], err_v[2], fa_v[2], fb_v[2]} !== {1'b0, 1'b1, 13'd0})
            $display("FAIL s0_restart_clear: got done=%0b busy=%0b err=%0d fa=%0d fb=%0d expected 0 1 0 0 0",
                     done_v[2], busy_v[2], err_v[2], fa_v[2], fb_v[2]);
        else n_pass++;
        wait_done(2, 1'b0, cyc);
        n_checks++;
        if (cyc != 128) $display("FAIL s0_restart_latency: got %0d expected 128", cyc);
        else n_pass++;
        n_checks++;
        if ({pass_v[2], err_v[2]} !== {1'b1, 7'd0})
            $display("FAIL s0_restart_pass: got pass=%0b err=%0d expected 1 0", pass_v[2], err_v[2]);
        else n_pass++;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_nor_pass();
        test_stuck_bit();
        test_wrong_op();
        test_busy_restart();
        test_reset_mid();
        test_restart_in_done();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
